// File: rtl/alu_op_sequencer.sv
// Sequencer that drives a combinational 32-bit ALU: accepts requests, holds
// operands for a settle window, captures result/flags and returns them.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_out,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned SCNT_W = 4;

    localparam logic [SCNT_W-1:0] SETTLE_INIT = SCNT_W'(SETTLE_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB = 3'd6;
    localparam logic [OP_W-1:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SCNT_W-1:0]   r_cnt;
    logic                r_err_pend;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_rsp_out;
    logic                r_rsp_zero;
    logic                r_rsp_overflow;
    logic                r_rsp_cout;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_ovf_cnt;

    logic                w_req_ready;
    logic                w_rsp_valid;
    logic                w_busy;
    logic                w_req_fire;
    logic                w_op_legal;
    logic                w_capture;
    logic                w_ovf_event;

    assign w_req_fire  = req_valid && (r_state == S_IDLE);
    assign w_op_legal  = (req_op == OP_AND) || (req_op == OP_OR) || (req_op == OP_ADD) ||
                         (req_op == OP_SUB) || (req_op == OP_SLT);
    assign w_capture   = (r_state == S_SETTLE) && (r_cnt == '0);
    assign w_ovf_event = alu_overflow && ((r_alu_op == OP_ADD) || (r_alu_op == OP_SUB));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req_fire) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded handshake/status outputs
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_RESP:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Illegal ops spend one SETTLE cycle with the counter at zero so the error
    // response lands one cycle after accept, without touching the ALU inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_err_pend     <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_rsp_out      <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_cout     <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_ovf_cnt      <= '0;
        end else begin
            if (w_req_fire) begin
                r_err_pend <= !w_op_legal;
                r_cnt      <= w_op_legal ? SETTLE_INIT : '0;
                if (w_op_legal) begin
                    r_alu_a  <= req_a;
                    r_alu_b  <= req_b;
                    r_alu_op <= req_op;
                end
            end else if ((r_state == S_SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - SCNT_W'(1);
            end

            if (w_capture) begin
                if (r_err_pend) begin
                    r_rsp_out      <= '0;
                    r_rsp_zero     <= 1'b0;
                    r_rsp_overflow <= 1'b0;
                    r_rsp_cout     <= 1'b0;
                    r_rsp_err      <= 1'b1;
                end else begin
                    r_rsp_out      <= alu_out;
                    r_rsp_zero     <= alu_zero;
                    r_rsp_overflow <= alu_overflow;
                    r_rsp_cout     <= alu_cout;
                    r_rsp_err      <= 1'b0;
                    if (w_ovf_event && (r_ovf_cnt != '1)) begin
                        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign req_ready    = w_req_ready;
    assign rsp_valid    = w_rsp_valid;
    assign busy         = w_busy;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign rsp_out      = r_rsp_out;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_err      = r_rsp_err;
    assign ovf_count    = r_ovf_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the DUT's ALU port plus an
// arithmetic reference model for responses, latency and overflow counting.
module tb_alu_op_sequencer;

    localparam int unsigned S   = 4;
    localparam int unsigned CW  = 3;
    localparam int unsigned TMO = 64;
    localparam longint MAXS = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINS = -64'sh0000_0000_8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [2:0]    alu_op;
    logic [31:0]   alu_out;
    logic          alu_zero;
    logic          alu_overflow;
    logic          alu_cout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_out;
    logic          rsp_zero;
    logic          rsp_overflow;
    logic          rsp_cout;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] ovf_count;

    int n_vec = 0;
    int n_err = 0;

    int          exp_ovf;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_op;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout),
        .rsp_err(rsp_err), .busy(busy), .ovf_count(ovf_count)
    );

    // Gate-level-style ALU: adder flags are produced for every opcode
    logic [31:0] w_bb;
    logic [32:0] w_sum;
    logic        w_ovf;
    always_comb begin
        w_bb  = alu_op[2] ? ~alu_b : alu_b;
        w_sum = {1'b0, alu_a} + {1'b0, w_bb} + 33'(alu_op[2]);
        w_ovf = (alu_a[31] == w_bb[31]) && (w_sum[31] != alu_a[31]);
        case (alu_op)
            3'd0:    alu_out = alu_a & alu_b;
            3'd1:    alu_out = alu_a | alu_b;
            3'd2:    alu_out = w_sum[31:0];
            3'd6:    alu_out = w_sum[31:0];
            3'd7:    alu_out = {31'd0, w_sum[31] ^ w_ovf};
            default: alu_out = 32'd0;
        endcase
        alu_zero     = (alu_out == 32'd0);
        alu_overflow = w_ovf;
        alu_cout     = w_sum[32];
    end

    function automatic bit is_legal(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd6) || (op == 3'd7);
    endfunction

    // Expected {out, zero, overflow, cout, err} from signed/unsigned arithmetic
    function automatic logic [35:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint sa, sb, ua, ub, full;
        logic [31:0] res;
        logic ov, co;
        bit sub;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = longint'(a);
        ub   = longint'(b);
        sub  = (op == 3'd6) || (op == 3'd7);
        full = sub ? (sa - sb) : (sa + sb);
        ov   = (full > MAXS) || (full < MINS);
        co   = sub ? (ua >= ub) : ((ua + ub) > 64'sh0000_0000_FFFF_FFFF);
        case (op)
            3'd0:    res = a & b;
            3'd1:    res = a | b;
            3'd2:    res = a + b;
            3'd6:    res = a - b;
            3'd7:    res = (sa < sb) ? 32'd1 : 32'd0;
            default: return 36'h1;
        endcase
        return {res, (res == 32'd0), ov, co, 1'b0};
    endfunction

    task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [35:0] r;
        r = ref_rsp(a, b, op);
        if (is_legal(op)) begin
            exp_a  = a;
            exp_b  = b;
            exp_op = op;
            if (((op == 3'd2) || (op == 3'd6)) && r[2] && (exp_ovf < (1 << CW) - 1)) exp_ovf++;
        end
    endtask

    task automatic model_reset();
        exp_ovf = 0;
        exp_a   = '0;
        exp_b   = '0;
        exp_op  = '0;
    endtask

    // Issue one request and wait for rsp_valid; leaves rsp_ready low
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output int lat, output bit to);
        int w;
        to  = 1'b0;
        lat = 0;
        w   = 0;
        rsp_ready = 1'b0;
        while (!req_ready && w < TMO) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) to = 1'b1;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a  = $urandom;
        req_b  = $urandom;
        req_op = 3'($urandom);
        while (!rsp_valid && lat < TMO) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) to = 1'b1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        model_reset();
        n_vec++;
        if ({req_ready, rsp_valid, busy, alu_a, alu_b, alu_op, rsp_out, rsp_zero, rsp_overflow,
             rsp_cout, rsp_err, ovf_count} !== {1'b1, 1'b0, 1'b0, 67'd0, 36'd0, CW'(0)}) begin
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b alu_a=%h rsp_out=%h ovf=%0d want 1/0/0/0/0/0",
                     req_ready, rsp_valid, busy, alu_a, rsp_out, ovf_count);
            n_err++;
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [14] = '{32'd4, 32'h1234_5678, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                                 32'h4000_0000, -32'sd50, -32'sd45, 32'h8000_0000, 32'h8000_0000,
                                 32'hDEAD_0000, 32'h0000_00F0, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] tb [14] = '{32'd9, 32'h1234_5678, 32'd1, 32'd1, 32'hF0F0_F0F0,
                                 32'h4000_0000, -32'sd49, -32'sd125123, 32'd1, 32'd1,
                                 32'h0000_BEEF, 32'h0000_0F00, 32'h0, 32'd1};
        logic [2:0]  to_ [14] = '{3'd2, 3'd6, 3'd2, 3'd3, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd6,
                                  3'd4, 3'd1, 3'd5, 3'd2};
        for (int i = 0; i < 14; i++) begin
            int lat;
            bit tmo;
            int exp_lat;
            logic [35:0] er;
            issue(ta[i], tb[i], to_[i], lat, tmo);
            exp_lat = is_legal(to_[i]) ? S : 1;
            er = ref_rsp(ta[i], tb[i], to_[i]);
            model_accept(ta[i], tb[i], to_[i]);
            n_vec++;
            if (tmo || lat != exp_lat) begin
                $display("FAIL dir_latency[%0d]: got %0d (timeout=%0b) want %0d", i, lat, tmo, exp_lat);
                n_err++;
            end
            n_vec++;
            if ({rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== er) begin
                $display("FAIL dir_rsp[%0d] op=%0d: got out=%h z%b v%b c%b e%b want %h",
                         i, to_[i], rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err, er);
                n_err++;
            end
            n_vec++;
            if ({alu_a, alu_b, alu_op} !== {exp_a, exp_b, exp_op}) begin
                $display("FAIL dir_alu_in[%0d]: got %h/%h/%0d want %h/%h/%0d",
                         i, alu_a, alu_b, alu_op, exp_a, exp_b, exp_op);
                n_err++;
            end
            n_vec++;
            if (ovf_count !== CW'(exp_ovf)) begin
                $display("FAIL dir_ovf_count[%0d]: got %0d want %0d", i, ovf_count, exp_ovf);
                n_err++;
            end
            release_rsp();
            n_vec++;
            if ({rsp_valid, req_ready, busy} !== 3'b010) begin
                $display("FAIL dir_return_idle[%0d]: got vld/rdy/busy=%b want 010", i,
                         {rsp_valid, req_ready, busy});
                n_err++;
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit tmo;
        logic [35:0] er;
        issue(32'h0000_00F0, 32'h0000_0F00, 3'd6, lat, tmo);
        er = ref_rsp(32'h0000_00F0, 32'h0000_0F00, 3'd6);
        model_accept(32'h0000_00F0, 32'h0000_0F00, 3'd6);
        n_vec++;
        if (tmo || lat != S) begin
            $display("FAIL bp_latency: got %0d want %0d", lat, S);
            n_err++;
        end
        for (int k = 0; k < 10; k++) begin
            req_valid = 1'b1;
            req_op    = 3'd2;
            req_a     = $urandom;
            req_b     = $urandom;
            @(posedge clk); #1;
            n_vec++;
            if ({rsp_valid, req_ready, rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err, alu_a, alu_b, alu_op}
                !== {2'b10, er, exp_a, exp_b, exp_op}) begin
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b out=%h alu_a=%h want 1/0/%h/%h",
                         k, rsp_valid, req_ready, rsp_out, alu_a, er[35:4], exp_a);
                n_err++;
            end
        end
        req_valid = 1'b0;
        release_rsp();
        n_vec++;
        if ({rsp_valid, req_ready, busy, rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err}
            !== {3'b010, er}) begin
            $display("FAIL bp_release: got vld/rdy/busy=%b out=%h want 010 %h",
                     {rsp_valid, req_ready, busy}, rsp_out, er[35:4]);
            n_err++;
        end
    endtask

    task automatic test_random();
        logic [2:0] op_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd6, 3'd6, 3'd7, 3'd3, 3'd4, 3'd5};
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [2:0]  op;
            logic [35:0] er;
            int lat;
            bit tmo;
            int exp_lat;
            case ($urandom_range(0, 3))
                0:       a = 32'h7FFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'h0000_0001;
                1:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            op = op_tab[$urandom_range(0, 9)];
            issue(a, b, op, lat, tmo);
            exp_lat = is_legal(op) ? S : 1;
            er = ref_rsp(a, b, op);
            model_accept(a, b, op);
            n_vec++;
            if (tmo || lat != exp_lat) begin
                $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, exp_lat);
                n_err++;
            end
            n_vec++;
            if ({rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== er) begin
                $display("FAIL rnd_rsp[%0d] a=%h b=%h op=%0d: got %h z%b v%b c%b e%b want %h",
                         i, a, b, op, rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err, er);
                n_err++;
            end
            n_vec++;
            if ({alu_a, alu_b, alu_op, ovf_count} !== {exp_a, exp_b, exp_op, CW'(exp_ovf)}) begin
                $display("FAIL rnd_alu_ovf[%0d]: got %h/%h/%0d cnt=%0d want %h/%h/%0d cnt=%0d",
                         i, alu_a, alu_b, alu_op, ovf_count, exp_a, exp_b, exp_op, exp_ovf);
                n_err++;
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            release_rsp();
        end
    endtask

    task automatic test_reset_mid_settle();
        bit seen;
        req_valid = 1'b1;
        req_a = 32'd5; req_b = 32'd5; req_op = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_vec++;
        if ({req_ready, rsp_valid, busy, alu_a, alu_b, alu_op, rsp_out, rsp_zero, rsp_overflow,
             rsp_cout, rsp_err, ovf_count} !== {1'b1, 1'b0, 1'b0, 67'd0, 36'd0, CW'(0)}) begin
            $display("FAIL rst_mid_settle: got rdy=%b vld=%b alu_a=%h rsp_out=%h ovf=%0d want 1/0/0/0/0",
                     req_ready, rsp_valid, alu_a, rsp_out, ovf_count);
            n_err++;
        end
        seen = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin
            $display("FAIL rst_dropped_op: got rsp_valid seen=%b want 0", seen);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int w;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a = 32'd1; req_b = 32'd2; req_op = 3'd2;
        for (int c = 0; c < 40; c++) begin
            if (req_ready) acc.push_back(c);
            if (rsp_valid) begin
                n_vec++;
                if ({rsp_out, rsp_err} !== {32'd3, 1'b0}) begin
                    $display("FAIL b2b_rsp[%0d]: got %h err=%b want 3 err=0", c, rsp_out, rsp_err);
                    n_err++;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        model_accept(32'd1, 32'd2, 3'd2);
        w = 0;
        while (busy && w < TMO) begin @(posedge clk); #1; w++; end
        rsp_ready = 1'b0;
        n_vec++;
        if (acc.size() != 7 || busy) begin
            $display("FAIL b2b_accepts: got %0d accepts busy=%b want 7 busy=0", acc.size(), busy);
            n_err++;
        end
        for (int k = 1; k < acc.size(); k++) begin
            n_vec++;
            if (acc[k] - acc[k-1] != S + 2) begin
                $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, acc[k] - acc[k-1], S + 2);
                n_err++;
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            int lat;
            bit tmo;
            issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd2, lat, tmo);
            model_accept(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd2);
            n_vec++;
            if (tmo || ovf_count !== CW'(exp_ovf) || rsp_overflow !== 1'b1) begin
                $display("FAIL sat_count[%0d]: got %0d ovf=%b want %0d ovf=1", i, ovf_count,
                         rsp_overflow, exp_ovf);
                n_err++;
            end
            release_rsp();
        end
        n_vec++;
        if (ovf_count !== {CW{1'b1}}) begin
            $display("FAIL sat_final: got %0d want %0d", ovf_count, (1 << CW) - 1);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_settle();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
